// File: rtl/instr_encode.sv
// instr_encode: RV32I instruction encoder with immediate range checks and a 2-entry
// address-tagged output FIFO. Rev 1.0
`default_nettype none

package instr_type;
  localparam int REGISTER_DESCRIPTOR_WIDTH = 5;
  localparam int OPERAND_WIDTH             = 32;

  typedef enum logic [5:0] {
    KIND_LUI, KIND_AUIPC, KIND_JAL, KIND_JALR,
    KIND_BEQ, KIND_BNE, KIND_BLT, KIND_BGE, KIND_BLTU, KIND_BGEU,
    KIND_LB, KIND_LH, KIND_LW, KIND_LBU, KIND_LHU,
    KIND_SB, KIND_SH, KIND_SW,
    KIND_ADDI, KIND_SLTI, KIND_SLTIU, KIND_XORI, KIND_ORI, KIND_ANDI,
    KIND_SLLI, KIND_SRLI, KIND_SRAI,
    KIND_ADD, KIND_SUB, KIND_SLL, KIND_SLT, KIND_SLTU, KIND_XOR, KIND_SRL, KIND_SRA,
    KIND_OR, KIND_AND,
    KIND_FENCE, KIND_FENCE_I, KIND_ECALL, KIND_EBREAK,
    KIND_CSRRW, KIND_CSRRS, KIND_CSRRC, KIND_CSRRWI, KIND_CSRRSI, KIND_CSRRCI
  } instr_kind_t;
endpackage

module instr_encode
  import instr_type::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 restart,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  instr_kind_t                          in_kind,
  input  logic [REGISTER_DESCRIPTOR_WIDTH-1:0] in_rs1,
  input  logic [REGISTER_DESCRIPTOR_WIDTH-1:0] in_rs2,
  input  logic [REGISTER_DESCRIPTOR_WIDTH-1:0] in_rd,
  input  logic [OPERAND_WIDTH-1:0]             in_imm,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [31:0]                          out_instr,
  output logic [31:0]                          out_addr,
  output logic                                 err_imm,
  output logic [15:0]                          err_count
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_ALT = 7'b0100000;

  localparam logic [3:0] FMT_BAD   = 4'd0;
  localparam logic [3:0] FMT_R     = 4'd1;
  localparam logic [3:0] FMT_I     = 4'd2;
  localparam logic [3:0] FMT_SH    = 4'd3;
  localparam logic [3:0] FMT_S     = 4'd4;
  localparam logic [3:0] FMT_B     = 4'd5;
  localparam logic [3:0] FMT_U     = 4'd6;
  localparam logic [3:0] FMT_J     = 4'd7;
  localparam logic [3:0] FMT_FENCE = 4'd8;
  localparam logic [3:0] FMT_SYS   = 4'd9;

  logic [3:0]  fmt;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [11:0] sys_imm;
  logic [31:0] enc_word;
  logic        enc_legal;

  logic fits_12, fits_sh, fits_b, fits_j, fits_u;

  assign fits_12 = ($signed(in_imm) >= -32'sd2048) && ($signed(in_imm) <= 32'sd2047);
  assign fits_sh = (in_imm <= 32'd31);
  assign fits_b  = ($signed(in_imm) >= -32'sd4096) && ($signed(in_imm) <= 32'sd4094) && !in_imm[0];
  assign fits_j  = ($signed(in_imm) >= -32'sd1048576) && ($signed(in_imm) <= 32'sd1048574) && !in_imm[0];
  assign fits_u  = (in_imm[11:0] == 12'h000);

  // Kind decode: pick the field layout, opcode and function codes.
  always_comb begin
    fmt     = FMT_BAD;
    opc     = 7'b0;
    f3      = 3'b000;
    f7      = 7'b0;
    sys_imm = 12'h000;
    case (in_kind)
      KIND_LUI:     begin fmt = FMT_U;     opc = OPC_LUI;                 end
      KIND_AUIPC:   begin fmt = FMT_U;     opc = OPC_AUIPC;               end
      KIND_JAL:     begin fmt = FMT_J;     opc = OPC_JAL;                 end
      KIND_JALR:    begin fmt = FMT_I;     opc = OPC_JALR;   f3 = 3'b000; end
      KIND_BEQ:     begin fmt = FMT_B;     opc = OPC_BRANCH; f3 = 3'b000; end
      KIND_BNE:     begin fmt = FMT_B;     opc = OPC_BRANCH; f3 = 3'b001; end
      KIND_BLT:     begin fmt = FMT_B;     opc = OPC_BRANCH; f3 = 3'b100; end
      KIND_BGE:     begin fmt = FMT_B;     opc = OPC_BRANCH; f3 = 3'b101; end
      KIND_BLTU:    begin fmt = FMT_B;     opc = OPC_BRANCH; f3 = 3'b110; end
      KIND_BGEU:    begin fmt = FMT_B;     opc = OPC_BRANCH; f3 = 3'b111; end
      KIND_LB:      begin fmt = FMT_I;     opc = OPC_LOAD;   f3 = 3'b000; end
      KIND_LH:      begin fmt = FMT_I;     opc = OPC_LOAD;   f3 = 3'b001; end
      KIND_LW:      begin fmt = FMT_I;     opc = OPC_LOAD;   f3 = 3'b010; end
      KIND_LBU:     begin fmt = FMT_I;     opc = OPC_LOAD;   f3 = 3'b100; end
      KIND_LHU:     begin fmt = FMT_I;     opc = OPC_LOAD;   f3 = 3'b101; end
      KIND_SB:      begin fmt = FMT_S;     opc = OPC_STORE;  f3 = 3'b000; end
      KIND_SH:      begin fmt = FMT_S;     opc = OPC_STORE;  f3 = 3'b001; end
      KIND_SW:      begin fmt = FMT_S;     opc = OPC_STORE;  f3 = 3'b010; end
      KIND_ADDI:    begin fmt = FMT_I;     opc = OPC_OPIMM;  f3 = 3'b000; end
      KIND_SLTI:    begin fmt = FMT_I;     opc = OPC_OPIMM;  f3 = 3'b010; end
      KIND_SLTIU:   begin fmt = FMT_I;     opc = OPC_OPIMM;  f3 = 3'b011; end
      KIND_XORI:    begin fmt = FMT_I;     opc = OPC_OPIMM;  f3 = 3'b100; end
      KIND_ORI:     begin fmt = FMT_I;     opc = OPC_OPIMM;  f3 = 3'b110; end
      KIND_ANDI:    begin fmt = FMT_I;     opc = OPC_OPIMM;  f3 = 3'b111; end
      KIND_SLLI:    begin fmt = FMT_SH;    opc = OPC_OPIMM;  f3 = 3'b001; end
      KIND_SRLI:    begin fmt = FMT_SH;    opc = OPC_OPIMM;  f3 = 3'b101; end
      KIND_SRAI:    begin fmt = FMT_SH;    opc = OPC_OPIMM;  f3 = 3'b101; f7 = F7_ALT; end
      KIND_ADD:     begin fmt = FMT_R;     opc = OPC_OP;     f3 = 3'b000; end
      KIND_SUB:     begin fmt = FMT_R;     opc = OPC_OP;     f3 = 3'b000; f7 = F7_ALT; end
      KIND_SLL:     begin fmt = FMT_R;     opc = OPC_OP;     f3 = 3'b001; end
      KIND_SLT:     begin fmt = FMT_R;     opc = OPC_OP;     f3 = 3'b010; end
      KIND_SLTU:    begin fmt = FMT_R;     opc = OPC_OP;     f3 = 3'b011; end
      KIND_XOR:     begin fmt = FMT_R;     opc = OPC_OP;     f3 = 3'b100; end
      KIND_SRL:     begin fmt = FMT_R;     opc = OPC_OP;     f3 = 3'b101; end
      KIND_SRA:     begin fmt = FMT_R;     opc = OPC_OP;     f3 = 3'b101; f7 = F7_ALT; end
      KIND_OR:      begin fmt = FMT_R;     opc = OPC_OP;     f3 = 3'b110; end
      KIND_AND:     begin fmt = FMT_R;     opc = OPC_OP;     f3 = 3'b111; end
      KIND_FENCE:   begin fmt = FMT_FENCE; opc = OPC_MISC;   f3 = 3'b000; end
      KIND_FENCE_I: begin fmt = FMT_FENCE; opc = OPC_MISC;   f3 = 3'b001; end
      KIND_ECALL:   begin fmt = FMT_SYS;   sys_imm = 12'h000;             end
      KIND_EBREAK:  begin fmt = FMT_SYS;   sys_imm = 12'h001;             end
      // CSR forms share the I layout; the immediate variants carry zimm in rs1.
      KIND_CSRRW:   begin fmt = FMT_I;     opc = OPC_SYSTEM; f3 = 3'b001; end
      KIND_CSRRS:   begin fmt = FMT_I;     opc = OPC_SYSTEM; f3 = 3'b010; end
      KIND_CSRRC:   begin fmt = FMT_I;     opc = OPC_SYSTEM; f3 = 3'b011; end
      KIND_CSRRWI:  begin fmt = FMT_I;     opc = OPC_SYSTEM; f3 = 3'b101; end
      KIND_CSRRSI:  begin fmt = FMT_I;     opc = OPC_SYSTEM; f3 = 3'b110; end
      KIND_CSRRCI:  begin fmt = FMT_I;     opc = OPC_SYSTEM; f3 = 3'b111; end
      default:      begin fmt = FMT_BAD; end
    endcase
  end

  always_comb begin
    enc_word  = 32'h0;
    enc_legal = 1'b0;
    case (fmt)
      FMT_R:     begin enc_word = {f7, in_rs2, in_rs1, f3, in_rd, opc}; enc_legal = 1'b1; end
      FMT_I:     begin enc_word = {in_imm[11:0], in_rs1, f3, in_rd, opc}; enc_legal = fits_12; end
      FMT_FENCE: begin enc_word = {in_imm[11:0], in_rs1, f3, in_rd, opc}; enc_legal = 1'b1; end
      FMT_SH:    begin enc_word = {f7, in_imm[4:0], in_rs1, f3, in_rd, opc}; enc_legal = fits_sh; end
      FMT_S:     begin enc_word = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], opc}; enc_legal = fits_12; end
      FMT_B:     begin
        enc_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3, in_imm[4:1], in_imm[11], opc};
        enc_legal = fits_b;
      end
      FMT_U:     begin enc_word = {in_imm[31:12], in_rd, opc}; enc_legal = fits_u; end
      FMT_J:     begin
        enc_word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, opc};
        enc_legal = fits_j;
      end
      FMT_SYS:   begin enc_word = {sys_imm, 13'b0, OPC_SYSTEM}; enc_legal = 1'b1; end
      default:   begin enc_word = 32'h0; enc_legal = 1'b0; end
    endcase
  end

  logic [1:0]  count;
  logic [31:0] slot0_instr, slot0_addr, slot1_instr, slot1_addr;
  logic [31:0] next_addr;
  logic        accept, push, pop, drop;

  assign in_ready  = (count != 2'd2) && !restart;
  assign out_valid = (count != 2'd0);
  assign out_instr = out_valid ? slot0_instr : 32'h0;
  assign out_addr  = out_valid ? slot0_addr  : 32'h0;

  assign accept = in_valid && in_ready;
  assign push   = accept && enc_legal;
  assign drop   = accept && !enc_legal;
  assign pop    = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count       <= 2'd0;
      slot0_instr <= 32'h0;
      slot0_addr  <= 32'h0;
      slot1_instr <= 32'h0;
      slot1_addr  <= 32'h0;
      next_addr   <= BASE_ADDR;
      err_imm     <= 1'b0;
      err_count   <= 16'h0;
    end else if (restart) begin
      count     <= 2'd0;
      next_addr <= BASE_ADDR;
      err_imm   <= 1'b0;
    end else begin
      err_imm <= drop;
      if (drop && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
      if (push) next_addr <= next_addr + 32'd4;
      // Push with pop only occurs at occupancy 1, since a full FIFO blocks pushes.
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            slot0_instr <= enc_word;
            slot0_addr  <= next_addr;
          end else begin
            slot1_instr <= enc_word;
            slot1_addr  <= next_addr;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0_instr <= slot1_instr;
          slot0_addr  <= slot1_addr;
          count       <= count - 2'd1;
        end
        2'b11: begin
          slot0_instr <= enc_word;
          slot0_addr  <= next_addr;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_encode.sv
// tb_instr_encode: directed vectors with a queue scoreboard for instr_encode.
`default_nettype none

module tb_instr_encode;
  import instr_type::*;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        restart = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  instr_kind_t in_kind = KIND_ADD;
  logic [4:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr, out_addr;
  logic        err_imm;
  logic [15:0] err_count;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];
  logic [31:0] model_addr = BASE;

  instr_encode #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .restart(restart),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .err_imm(err_imm), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every word the consumer takes must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: got instr=%h addr=%h expected none", out_instr, out_addr);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("out_instr", out_instr, e[63:32]);
        check("out_addr", out_addr, e[31:0]);
      end
    end
  end

  task automatic drive(input instr_kind_t k, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm);
    in_kind  = k;
    in_rd    = rd;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_imm   = imm;
    in_valid = 1'b1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input instr_kind_t k, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm, input logic [31:0] exp,
                      input bit legal, input string name);
    int waited;
    drive(k, rd, rs1, rs2, imm);
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL %s_accept: got in_ready=0 expected 1 within 50 cycles", name);
      @(posedge clk);
      #1 in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (legal) begin
      exp_q.push_back({exp, model_addr});
      model_addr += 32'd4;
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic send_bad(input instr_kind_t k, input logic [31:0] imm, input string name);
    send(k, 5'd1, 5'd1, 5'd2, imm, 32'h0, 1'b0, name);
    @(negedge clk);
    check({name, "_err_imm"}, {31'b0, err_imm}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_drain: got %0d words pending expected 0", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(posedge clk);
    exp_q.delete();
    model_addr = BASE;
    #1 restart = 1'b0;
  endtask

  initial begin
    #12;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_addr", out_addr, 32'h0);
    check("rst_err_imm", {31'b0, err_imm}, 32'd0);
    check("rst_err_count", {16'b0, err_count}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Single word, one-cycle latency
    send(KIND_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1'b1, "addi");
    @(negedge clk);
    check("addi_latency_valid", {31'b0, out_valid}, 32'd1);
    @(posedge clk);
    #1;

    // Back-to-back
    send(KIND_SUB, 5'd3, 5'd1, 5'd2, 32'd0,    32'h402081B3, 1'b1, "sub");
    send(KIND_BEQ, 5'd0, 5'd1, 5'd2, 32'd8,    32'h00208463, 1'b1, "beq");
    send(KIND_JAL, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h001000EF, 1'b1, "jal");
    drain("b2b");
    do_restart();

    // Backpressure: two accepted, third held off
    out_ready = 1'b0;
    send(KIND_ADDI, 5'd2, 5'd1, 5'd0, 32'hFFFF_FFFF, 32'hFFF08113, 1'b1, "bp_a");
    send(KIND_SUB,  5'd3, 5'd1, 5'd2, 32'd0,         32'h402081B3, 1'b1, "bp_b");
    drive(KIND_LUI, 5'd7, 5'd0, 5'd0, 32'h12345000);
    @(negedge clk);
    check("bp_in_ready_full", {31'b0, in_ready}, 32'd0);
    check("bp_head_instr", out_instr, 32'hFFF08113);
    check("bp_head_addr", out_addr, 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_in_ready_hold", {31'b0, in_ready}, 32'd0);
    check("bp_head_stable", out_instr, 32'hFFF08113);
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(KIND_LUI, 5'd7, 5'd0, 5'd0, 32'h12345000, 32'h123453B7, 1'b1, "bp_c");
    drain("bp");
    do_restart();

    // Illegal immediates are dropped
    send_bad(KIND_ADDI, 32'd2048, "bad_addi");
    send_bad(KIND_BEQ,  32'd7,    "bad_beq");
    send_bad(KIND_SLLI, 32'd32,   "bad_slli");
    @(negedge clk);
    check("bad_err_count", {16'b0, err_count}, 32'd3);
    check("bad_no_output", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    send(KIND_SRAI, 5'd2, 5'd3, 5'd0, 32'd31, 32'h41F1D113, 1'b1, "srai");
    drain("bad");

    // Restart with two words buffered and a concurrent request
    out_ready = 1'b0;
    send(KIND_SW,   5'd0, 5'd2, 5'd5, 32'hFFFF_FFFC, 32'hFE512E23, 1'b1, "sw");
    send(KIND_ADDI, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800, 32'h80000093, 1'b1, "addi_min");
    restart = 1'b1;
    drive(KIND_ADDI, 5'd1, 5'd0, 5'd0, 32'd5);
    @(negedge clk);
    check("restart_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    exp_q.delete();
    model_addr = BASE;
    #1;
    restart  = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("restart_out_valid", {31'b0, out_valid}, 32'd0);
    check("restart_err_imm", {31'b0, err_imm}, 32'd0);
    check("restart_err_count", {16'b0, err_count}, 32'd3);
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(KIND_LUI, 5'd7, 5'd0, 5'd0, 32'h12345000, 32'h123453B7, 1'b1, "post_restart");
    drain("restart");

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    send(KIND_ECALL,  5'd0, 5'd0, 5'd0, 32'd0, 32'h00000073, 1'b1, "pre_rst_a");
    send(KIND_EBREAK, 5'd0, 5'd0, 5'd0, 32'd0, 32'h00100073, 1'b1, "pre_rst_b");
    #2 rst = 1'b0;
    exp_q.delete();
    #1;
    check("arst_out_valid", {31'b0, out_valid}, 32'd0);
    check("arst_out_instr", out_instr, 32'h0);
    check("arst_out_addr", out_addr, 32'h0);
    check("arst_in_ready", {31'b0, in_ready}, 32'd1);
    check("arst_err_count", {16'b0, err_count}, 32'd0);
    @(posedge clk);
    #1;
    rst        = 1'b1;
    model_addr = BASE;
    out_ready  = 1'b1;

    // System and CSR encodings
    send(KIND_ECALL,  5'd0, 5'd0, 5'd0, 32'd0,     32'h00000073, 1'b1, "ecall");
    send(KIND_EBREAK, 5'd0, 5'd0, 5'd0, 32'd0,     32'h00100073, 1'b1, "ebreak");
    send(KIND_CSRRW,  5'd5, 5'd6, 5'd0, 32'h300,   32'h300312F3, 1'b1, "csrrw");
    drain("sys");

    // Non-zero low U bits and an unknown kind are both dropped
    send_bad(KIND_LUI, 32'h12345001, "bad_lui");
    send_bad(instr_kind_t'(6'd63), 32'd0, "bad_kind");
    @(negedge clk);
    check("final_err_count", {16'b0, err_count}, 32'd2);
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
